// File: rtl/register_file_nw_32b_1r_64b_1row_if.sv
// ---------------------------------------------------------------------------
// register_file_nw_32b_1r_64b_1row_if
//   Bus bundle for the single-row gather register. Producers drive the N_WRITE
//   narrow write ports; a single wide consumer reads and consumes the row.
//   master : producer/consumer side (drives writes and ReadEnable)
//   slave  : register side (returns collisions, read data and row status)
//   Signals:
//     WriteEnable[N_WRITE]            per-port write request
//     WriteAddr[N_WRITE][WADDR_WIDTH] half select (0 = low half, 1 = high half)
//     WriteData[N_WRITE][WDATA_WIDTH] write data
//     WriteCollision[N_WRITE]         pulse: port lost arbitration, write dropped
//     ReadEnable                      read and consume the row
//     ReadData[RDATA_WIDTH]           registered read data
//     ReadValid                       pulse: ReadData updated from a full row
//     HalfValid[2]                    per-half written-since-last-read flags
//     RowFull                         all halves valid
// ---------------------------------------------------------------------------
interface register_file_nw_32b_1r_64b_1row_if #(
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 64,
    parameter int WADDR_WIDTH = $clog2(RDATA_WIDTH / WDATA_WIDTH),
    parameter int N_WRITE     = 4
);
    localparam int N_HALF = RDATA_WIDTH / WDATA_WIDTH;

    logic [N_WRITE-1:0]                  WriteEnable;
    logic [N_WRITE-1:0][WADDR_WIDTH-1:0] WriteAddr;
    logic [N_WRITE-1:0][WDATA_WIDTH-1:0] WriteData;
    logic [N_WRITE-1:0]                  WriteCollision;
    logic                                ReadEnable;
    logic [RDATA_WIDTH-1:0]              ReadData;
    logic                                ReadValid;
    logic [N_HALF-1:0]                   HalfValid;
    logic                                RowFull;

    modport master (
        output WriteEnable, WriteAddr, WriteData, ReadEnable,
        input  WriteCollision, ReadData, ReadValid, HalfValid, RowFull
    );

    modport slave (
        input  WriteEnable, WriteAddr, WriteData, ReadEnable,
        output WriteCollision, ReadData, ReadValid, HalfValid, RowFull
    );
endinterface

// File: rtl/register_file_nw_32b_1r_64b_1row.sv
// ---------------------------------------------------------------------------
// register_file_nw_32b_1r_64b_1row
//   One 64b row built from two 32b halves, written through N_WRITE narrow
//   ports and read whole through one wide port. Writes are arbitrated per half
//   (lowest port index wins), staged for one cycle, then committed. A read
//   returns the pre-commit row, consumes the HalfValid flags and flags
//   ReadValid only if the row was complete.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  slave side of register_file_nw_32b_1r_64b_1row_if
// ---------------------------------------------------------------------------
module register_file_nw_32b_1r_64b_1row #(
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 64,
    parameter int WADDR_WIDTH = $clog2(RDATA_WIDTH / WDATA_WIDTH),
    parameter int N_WRITE     = 4
) (
    input  logic clk,
    input  logic rst,
    register_file_nw_32b_1r_64b_1row_if.slave bus
);
    localparam int N_HALF = RDATA_WIDTH / WDATA_WIDTH;

    // Arbitration results (combinational, from this cycle's requests)
    logic [N_HALF-1:0]                  win_en;
    logic [N_HALF-1:0][WDATA_WIDTH-1:0] win_data;
    logic [N_WRITE-1:0]                 lost;

    // Staging, memory and status state
    logic [N_HALF-1:0]                  stg_en;
    logic [N_HALF-1:0][WDATA_WIDTH-1:0] stg_data;
    logic [N_HALF-1:0][WDATA_WIDTH-1:0] mem;
    logic [N_HALF-1:0]                  half_valid;
    logic [N_WRITE-1:0]                 collision;
    logic [RDATA_WIDTH-1:0]             read_data;
    logic                               read_valid;
    logic                               row_full;

    // Ports are scanned in ascending order, so the first requester to claim a
    // half keeps it and every later requester for that half is a loser.
    always_comb begin
        win_en   = '0;
        win_data = '0;
        lost     = '0;
        for (int p = 0; p < N_WRITE; p++) begin
            if (bus.WriteEnable[p]) begin
                for (int h = 0; h < N_HALF; h++) begin
                    if (bus.WriteAddr[p] == WADDR_WIDTH'(h)) begin
                        if (win_en[h]) begin
                            lost[p] = 1'b1;
                        end else begin
                            win_en[h]   = 1'b1;
                            win_data[h] = bus.WriteData[p];
                        end
                    end
                end
            end
        end
    end

    assign row_full = &half_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_en     <= '0;
            stg_data   <= '0;
            mem        <= '0;
            half_valid <= '0;
            collision  <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            // Stage the winners; staging is simply overwritten every edge.
            stg_en    <= win_en;
            stg_data  <= win_data;
            collision <= lost;

            // The read samples mem before this edge's commit, so a write that
            // commits on the same edge is not bypassed into ReadData.
            if (bus.ReadEnable) begin
                read_data  <= mem;
                read_valid <= row_full;
            end else begin
                read_valid <= 1'b0;
            end

            // Commit staged halves; a commit on a read edge keeps its flag set.
            for (int h = 0; h < N_HALF; h++) begin
                if (stg_en[h]) begin
                    mem[h]        <= stg_data[h];
                    half_valid[h] <= 1'b1;
                end else if (bus.ReadEnable) begin
                    half_valid[h] <= 1'b0;
                end
            end
        end
    end

    assign bus.WriteCollision = collision;
    assign bus.ReadData       = read_data;
    assign bus.ReadValid      = read_valid;
    assign bus.HalfValid      = half_valid;
    assign bus.RowFull        = row_full;
endmodule

// File: tb/tb_register_file_nw_32b_1r_64b_1row.sv
// ---------------------------------------------------------------------------
// tb_register_file_nw_32b_1r_64b_1row
//   Directed bench for the single-row gather register: reset, fill and read,
//   collisions, read/commit ordering, partial reads and reset during a write.
// ---------------------------------------------------------------------------
module tb_register_file_nw_32b_1r_64b_1row;
    localparam int WDATA_WIDTH = 32;
    localparam int RDATA_WIDTH = 64;
    localparam int WADDR_WIDTH = 1;
    localparam int N_WRITE     = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    register_file_nw_32b_1r_64b_1row_if #(
        .WDATA_WIDTH(WDATA_WIDTH), .RDATA_WIDTH(RDATA_WIDTH),
        .WADDR_WIDTH(WADDR_WIDTH), .N_WRITE(N_WRITE)
    ) bus ();

    register_file_nw_32b_1r_64b_1row #(
        .WDATA_WIDTH(WDATA_WIDTH), .RDATA_WIDTH(RDATA_WIDTH),
        .WADDR_WIDTH(WADDR_WIDTH), .N_WRITE(N_WRITE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WriteEnable = '0;
        bus.WriteAddr   = '0;
        bus.WriteData   = '0;
        bus.ReadEnable  = 1'b0;
    endtask

    task automatic wr(input int p, input logic a, input logic [31:0] d);
        bus.WriteEnable[p] = 1'b1;
        bus.WriteAddr[p]   = a;
        bus.WriteData[p]   = d;
    endtask

    task automatic status(input string tag, input logic [63:0] rdata, input logic rvld,
                          input logic [1:0] hv, input logic [3:0] coll);
        check({tag, ".ReadData"},       bus.ReadData,       rdata);
        check({tag, ".ReadValid"},      bus.ReadValid,      rvld);
        check({tag, ".HalfValid"},      bus.HalfValid,      hv);
        check({tag, ".RowFull"},        bus.RowFull,        &hv);
        check({tag, ".WriteCollision"}, bus.WriteCollision, coll);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();

        // 1. Reset, with a write request present that must be discarded
        rst = 1'b1;
        wr(0, 1'b0, 32'h0000_0099);
        step();
        step();
        rst = 1'b0;
        idle();
        status("reset", 64'h0, 1'b0, 2'b00, 4'b0000);
        step();
        status("reset_idle", 64'h0, 1'b0, 2'b00, 4'b0000);

        // 2. Basic fill and read
        wr(0, 1'b0, 32'hAAAA_5555);
        step();                                  // t0: staged
        idle();
        wr(1, 1'b1, 32'h1234_5678);
        step();                                  // t1: half0 committed
        idle();
        status("fill_t1", 64'h0, 1'b0, 2'b01, 4'b0000);
        step();                                  // t1+1: half1 committed
        status("fill_full", 64'h0, 1'b0, 2'b11, 4'b0000);
        bus.ReadEnable = 1'b1;
        step();
        idle();
        status("fill_read", 64'h1234_5678_AAAA_5555, 1'b1, 2'b00, 4'b0000);
        step();
        status("read_hold", 64'h1234_5678_AAAA_5555, 1'b0, 2'b00, 4'b0000);

        // 3. Collision on half1: port0 wins, ports 2 and 3 dropped
        wr(0, 1'b1, 32'h11);
        wr(2, 1'b1, 32'h22);
        wr(3, 1'b1, 32'h33);
        step();
        idle();
        status("coll_pulse", 64'h1234_5678_AAAA_5555, 1'b0, 2'b00, 4'b1100);
        step();
        status("coll_commit", 64'h1234_5678_AAAA_5555, 1'b0, 2'b10, 4'b0000);
        bus.ReadEnable = 1'b1;
        step();
        idle();
        status("coll_read", 64'h0000_0011_AAAA_5555, 1'b0, 2'b00, 4'b0000);

        // 3b. Both halves won in one cycle by different ports
        wr(1, 1'b0, 32'h0B0B);
        wr(2, 1'b1, 32'h0C0C);
        wr(3, 1'b1, 32'h0D0D);
        step();
        idle();
        status("both_pulse", 64'h0000_0011_AAAA_5555, 1'b0, 2'b00, 4'b1000);
        step();
        status("both_commit", 64'h0000_0011_AAAA_5555, 1'b0, 2'b11, 4'b0000);
        bus.ReadEnable = 1'b1;
        step();
        idle();
        status("both_read", 64'h0000_0C0C_0000_0B0B, 1'b1, 2'b00, 4'b0000);

        // 4. No bypass and set-wins, then 5. partial read of half0 only
        wr(2, 1'b0, 32'hDEAD);
        step();
        idle();
        bus.ReadEnable = 1'b1;
        step();                                  // commit and read on one edge
        status("nobypass", 64'h0000_0C0C_0000_0B0B, 1'b0, 2'b01, 4'b0000);
        step();                                  // partial read
        idle();
        status("partial", 64'h0000_0C0C_0000_DEAD, 1'b0, 2'b00, 4'b0000);

        // 6. Reset while a write sits in staging
        wr(3, 1'b1, 32'hBEEF);
        step();
        idle();
        rst = 1'b1;
        wr(0, 1'b0, 32'h77);                     // sampled during reset
        step();
        rst = 1'b0;
        idle();
        status("rst_mid", 64'h0, 1'b0, 2'b00, 4'b0000);
        step();
        status("rst_mid_idle", 64'h0, 1'b0, 2'b00, 4'b0000);
        bus.ReadEnable = 1'b1;
        step();
        idle();
        status("rst_mid_read", 64'h0, 1'b0, 2'b00, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
